// File: rtl/capture_buffer_pkg.sv
// Shared definitions for the capture buffer.
// Holds the command encoding, the FSM state encoding, the command-payload field
// positions and a small helper that extracts the post-trigger field.
package capture_buffer_pkg;

  localparam int CMD_W        = 2;
  localparam int CMD_DATA_W   = 32;
  localparam int CFG_POST_LSB = 16;
  localparam int SKID_DEPTH   = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_ABORT = 2'd0,
    CMD_ARM   = 2'd1,
    CMD_READ  = 2'd2,
    CMD_CFG   = 2'd3
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_POST  = 3'd2,
    S_DONE  = 3'd3,
    S_READ  = 3'd4
  } state_e;

  // The whole upper half of the CFG word is taken as the post count, so that
  // values beyond the buffer depth can be detected and clamped.
  function automatic logic [31:0] cfg_post_field(input logic [CMD_DATA_W-1:0] d);
    return {16'h0000, d[CMD_DATA_W-1:CFG_POST_LSB]};
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM, one clock: one write port, one read port with a
// registered read (data appears the cycle after re). Contents are not reset.
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata output.
module sdp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Triggered capture buffer. Samples stream into a ring RAM while armed; a
// sample with tlast is the trigger, after which a configurable number of
// further samples is stored and capture stops. A READ command then streams
// the retained samples out oldest-first, with per-byte-group masking.
// Ports:
//   clk, rst               clock, async active-high reset
//   cmd_valid/code/data    command strobe (ABORT/ARM/READ/CFG) and CFG payload
//   mwr_*                  sample write stream (tlast = trigger)
//   mrd_*                  readout stream (tkeep = group mask)
//   busy                   high outside IDLE and DONE
module capture_buffer
  import capture_buffer_pkg::*;
#(
  parameter int MDW   = 32,
  parameter int GN    = MDW / 8,
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [CMD_W-1:0]      cmd_code,
  input  logic [CMD_DATA_W-1:0] cmd_data,
  input  logic                  mwr_tvalid,
  output logic                  mwr_tready,
  input  logic                  mwr_tlast,
  input  logic [MDW-1:0]        mwr_tdata,
  output logic                  mrd_tvalid,
  input  logic                  mrd_tready,
  output logic                  mrd_tlast,
  output logic [MDW-1:0]        mrd_tdata,
  output logic [GN-1:0]         mrd_tkeep,
  output logic                  busy
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FILL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   POST_MAX = AW'(DEPTH - 1);

  state_e state_q, state_d;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] post_len_q, post_len_d;   // configured post-trigger count
  logic [AW-1:0] post_cnt_q, post_cnt_d;   // samples still to take after trigger
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   iss_q, iss_d;             // RAM reads still to issue
  logic [AW:0]   rem_q, rem_d;             // samples still to hand out
  logic [GN-1:0] mask_q, mask_d;

  // Prefetch/skid: one RAM read in flight plus a 2-entry queue, entry 0 is head.
  logic                          infl_q, infl_d;
  logic [1:0]                    skid_cnt_q, skid_cnt_d;
  logic [SKID_DEPTH-1:0][MDW-1:0] skid_q, skid_d;

  cmd_e          cmd;
  logic          is_abort, is_arm, is_read, is_cfg;
  logic          wr_en, pop, rd_start, rd_issue, push_idx;
  logic [2:0]    occ;
  logic [AW-1:0] oldest, post_cfg;
  logic [31:0]   post_raw;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [MDW-1:0] ram_rdata;
  logic          unused_cmd_data;

  assign unused_cmd_data = ^cmd_data;

  assign cmd      = cmd_e'(cmd_code);
  assign is_abort = cmd_valid && (cmd == CMD_ABORT);
  assign is_arm   = cmd_valid && (cmd == CMD_ARM);
  assign is_read  = cmd_valid && (cmd == CMD_READ);
  assign is_cfg   = cmd_valid && (cmd == CMD_CFG);

  assign mwr_tready = (state_q == S_ARMED) || (state_q == S_POST);
  assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE));

  // A write coinciding with ARM is dropped; the pointers are being cleared.
  assign wr_en = mwr_tvalid && mwr_tready && !is_arm;

  assign mrd_tvalid = (state_q == S_READ) && (skid_cnt_q != 2'd0);
  assign mrd_tlast  = mrd_tvalid && (rem_q == (AW+1)'(1));
  assign mrd_tkeep  = mrd_tvalid ? mask_q : '0;
  assign pop        = mrd_tvalid && mrd_tready;

  assign oldest   = wptr_q - fill_q[AW-1:0];
  assign post_raw = cfg_post_field(cmd_data);
  assign post_cfg = (post_raw >= 32'(DEPTH)) ? POST_MAX : post_raw[AW-1:0];

  // The first read is launched in the very cycle READ is accepted, using the
  // oldest address directly, so data lands in the skid one cycle later.
  assign rd_start = is_read && (state_q == S_DONE) && (fill_q != '0);
  assign occ      = {1'b0, skid_cnt_q} + {2'b00, infl_q};
  // Issue only if the skid can hold the result: occupancy after this cycle's
  // pop must stay below two.
  assign rd_issue = (state_q == S_READ) && (iss_q != '0) &&
                    ((occ < 3'd2) || (pop && (occ == 3'd2)));
  assign ram_re    = rd_start || rd_issue;
  assign ram_raddr = rd_start ? oldest : rptr_q;

  // Slot the returning word lands in: current count minus any pop this cycle.
  assign push_idx = pop ? (skid_cnt_q == 2'd2) : (skid_cnt_q != 2'd0);

  sdp_ram #(.DW(MDW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (mwr_tdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  for (genvar g = 0; g < MDW / 8; g++) begin : g_byte
    if (g < GN) begin : g_on
      assign mrd_tdata[g*8 +: 8] = (mrd_tvalid && mask_q[g]) ? skid_q[0][g*8 +: 8] : 8'h00;
    end else begin : g_off
      assign mrd_tdata[g*8 +: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    post_len_d = post_len_q;
    post_cnt_d = post_cnt_q;
    fill_d     = fill_q;
    iss_d      = iss_q;
    rem_d      = rem_q;
    mask_d     = mask_q;
    skid_d     = skid_q;
    skid_cnt_d = skid_cnt_q + {1'b0, infl_q} - {1'b0, pop};
    infl_d     = ram_re;

    if (wr_en) begin
      wptr_d = wptr_q + AW'(1);
      if (fill_q != FILL_MAX) fill_d = fill_q + (AW+1)'(1);
    end

    if (pop) skid_d[0] = skid_q[1];
    if (infl_q) skid_d[push_idx] = ram_rdata;

    if (rd_issue) begin
      rptr_d = rptr_q + AW'(1);
      iss_d  = iss_q - (AW+1)'(1);
    end
    if (pop) rem_d = rem_q - (AW+1)'(1);

    if (is_cfg && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      mask_d     = cmd_data[GN-1:0];
      post_len_d = post_cfg;
    end

    case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        if (wr_en && mwr_tlast) begin
          if (post_len_q == '0) begin
            state_d = S_DONE;
          end else begin
            post_cnt_d = post_len_q;
            state_d    = S_POST;
          end
        end
      end
      S_POST: begin
        if (wr_en) begin
          post_cnt_d = post_cnt_q - AW'(1);
          if (post_cnt_q == AW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rd_start) begin
          state_d = S_READ;
          rptr_d  = oldest + AW'(1);
          iss_d   = fill_q - (AW+1)'(1);
          rem_d   = fill_q;
        end
      end
      S_READ: begin
        if (pop && (rem_q == (AW+1)'(1))) begin
          state_d    = S_DONE;
          skid_cnt_d = 2'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // ABORT and ARM override everything above and kill any readout; the word
    // possibly still coming out of the RAM is dropped by clearing infl.
    if (is_abort || is_arm) begin
      skid_cnt_d = 2'd0;
      infl_d     = 1'b0;
      iss_d      = '0;
      rem_d      = '0;
    end
    if (is_abort) state_d = S_IDLE;
    if (is_arm) begin
      state_d    = S_ARMED;
      wptr_d     = '0;
      fill_d     = '0;
      post_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      post_len_q <= '0;
      post_cnt_q <= '0;
      fill_q     <= '0;
      iss_q      <= '0;
      rem_q      <= '0;
      mask_q     <= '1;
      infl_q     <= 1'b0;
      skid_cnt_q <= 2'd0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      post_len_q <= post_len_d;
      post_cnt_q <= post_cnt_d;
      fill_q     <= fill_d;
      iss_q      <= iss_d;
      rem_q      <= rem_d;
      mask_q     <= mask_d;
      infl_q     <= infl_d;
      skid_cnt_q <= skid_cnt_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer (MDW=32, DEPTH=16). Expected readout words
// are queued when a scenario is set up and popped on every readout handshake.
module tb_capture_buffer;
  import capture_buffer_pkg::*;

  localparam int MDW = 32, GN = 4, DEPTH = 16;

  logic           clk, rst, cmd_valid;
  logic [1:0]     cmd_code;
  logic [31:0]    cmd_data;
  logic           mwr_tvalid, mwr_tready, mwr_tlast;
  logic [MDW-1:0] mwr_tdata;
  logic           mrd_tvalid, mrd_tready, mrd_tlast;
  logic [MDW-1:0] mrd_tdata;
  logic [GN-1:0]  mrd_tkeep;
  logic           busy;

  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];

  capture_buffer #(.MDW(MDW), .GN(GN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .mwr_tvalid(mwr_tvalid), .mwr_tready(mwr_tready), .mwr_tlast(mwr_tlast), .mwr_tdata(mwr_tdata),
    .mrd_tvalid(mrd_tvalid), .mrd_tready(mrd_tready), .mrd_tlast(mrd_tlast),
    .mrd_tdata(mrd_tdata), .mrd_tkeep(mrd_tkeep), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [1:0] code, input logic [31:0] data);
    cmd_valid = 1'b1; cmd_code = code; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_code = 2'd0; cmd_data = 32'h0;
  endtask

  task automatic write_seq(input logic [31:0] first, input int n, input logic [31:0] last_v,
                           output int acc);
    acc = 0;
    for (int i = 0; i < n; i++) begin
      mwr_tvalid = 1'b1; mwr_tdata = first + i; mwr_tlast = (first + i == last_v);
      if (!mwr_tready) break;
      acc++;
      @(posedge clk); #1;
    end
    mwr_tvalid = 1'b0; mwr_tlast = 1'b0;
  endtask

  task automatic drain(input int max_pops, input bit stall, input logic [GN-1:0] exp_keep);
    int pops = 0, first = -1, bubbles = 0;
    bit done = 0, prev_stall = 0;
    logic [31:0] h_data = 0, e;
    logic h_last = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      mrd_tready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (prev_stall) begin
        chk("hold_valid", mrd_tvalid, 1);
        chk("hold_data", mrd_tdata, h_data);
        chk("hold_last", mrd_tlast, h_last);
      end
      if (mrd_tvalid && first < 0) first = cyc;
      if (first >= 0 && mrd_tready && !mrd_tvalid) bubbles++;
      if (mrd_tvalid && mrd_tready) begin
        chk("rd_unexpected", exp_q.size() > 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        chk("rd_data", mrd_tdata, e);
        chk("rd_keep", mrd_tkeep, exp_keep);
        chk("rd_last", mrd_tlast, exp_q.size() == 0);
        pops++;
        if (mrd_tlast || pops == max_pops) done = 1;
      end
      prev_stall = mrd_tvalid && !mrd_tready;
      h_data = mrd_tdata; h_last = mrd_tlast;
      @(posedge clk); #1;
    end
    mrd_tready = 1'b0;
    chk("drain_done", done, 1);
    chk("first_latency_le2", (first >= 0) && (first <= 2), 1);
    if (!stall) chk("no_bubble", bubbles, 0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; cmd_valid = 0; cmd_code = 0; cmd_data = 0;
    mwr_tvalid = 0; mwr_tlast = 0; mwr_tdata = 0; mrd_tready = 0;

    // reset state
    #2;
    chk("rst_tready", mwr_tready, 0); chk("rst_rvalid", mrd_tvalid, 0);
    chk("rst_rlast", mrd_tlast, 0);   chk("rst_busy", busy, 0);
    chk("rst_rdata", mrd_tdata, 0);   chk("rst_rkeep", mrd_tkeep, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_tready", mwr_tready, 0);

    // basic capture: post=3, trigger on 5
    send_cmd(CMD_CFG, 32'h0003_000F);
    send_cmd(CMD_ARM, 32'h0);
    chk("armed_busy", busy, 1); chk("armed_tready", mwr_tready, 1);
    write_seq(32'h0, 10, 32'h5, acc);
    chk("basic_accepted", acc, 9);
    chk("basic_done_busy", busy, 0); chk("basic_done_tready", mwr_tready, 0);
    for (int i = 0; i <= 8; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 0, 4'hF);
    chk("basic_left", exp_q.size(), 0);
    chk("basic_back_done", busy, 0);

    // re-read same data under backpressure 1,0,0,1
    for (int i = 0; i <= 8; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 1, 4'hF);
    chk("bp_left", exp_q.size(), 0);

    // ring wrap: post=4, trigger on 25
    send_cmd(CMD_CFG, 32'h0004_000F);
    send_cmd(CMD_ARM, 32'h0);
    write_seq(32'h0, 32, 32'd25, acc);
    chk("wrap_accepted", acc, 30);
    for (int i = 14; i <= 29; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 0, 4'hF);
    chk("wrap_left", exp_q.size(), 0);

    // group mask, post=0, CFG ignored while armed
    send_cmd(CMD_CFG, 32'h0000_0005);
    send_cmd(CMD_ARM, 32'h0);
    send_cmd(CMD_CFG, 32'h0009_0003);
    write_seq(32'hAABB_CCDD, 2, 32'hAABB_CCDD, acc);
    chk("mask_accepted", acc, 1);
    exp_q.push_back(32'h00BB_00DD);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 0, 4'h5);
    chk("mask_left", exp_q.size(), 0);

    // post count above depth clamps to DEPTH-1: buffer ends exactly full
    send_cmd(CMD_CFG, 32'h00FF_000F);
    send_cmd(CMD_ARM, 32'h0);
    write_seq(32'h0, 21, 32'h0, acc);
    chk("clamp_accepted", acc, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 0, 4'hF);
    chk("clamp_left", exp_q.size(), 0);

    // ARM in the middle of a readout
    send_cmd(CMD_CFG, 32'h0002_000F);
    for (int i = 0; i < 16; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(3, 0, 4'hF);
    exp_q.delete();
    send_cmd(CMD_ARM, 32'h0);
    chk("arm_rd_valid", mrd_tvalid, 0);
    chk("arm_rd_tready", mwr_tready, 1);
    write_seq(32'd100, 6, 32'd101, acc);
    chk("arm_rd_accepted", acc, 4);
    for (int i = 100; i <= 103; i++) exp_q.push_back(i);
    send_cmd(CMD_READ, 32'h0);
    drain(100, 0, 4'hF);
    chk("arm_rd_left", exp_q.size(), 0);

    // ABORT, then READ in IDLE is ignored
    send_cmd(CMD_ARM, 32'h0);
    send_cmd(CMD_ABORT, 32'h0);
    chk("abort_busy", busy, 0); chk("abort_tready", mwr_tready, 0);
    mrd_tready = 1'b1;
    send_cmd(CMD_READ, 32'h0);
    repeat (3) @(posedge clk); #1;
    chk("idle_read_ignored", mrd_tvalid, 0);
    mrd_tready = 1'b0;

    // async reset while in POST with a write pending
    send_cmd(CMD_CFG, 32'h0005_000F);
    send_cmd(CMD_ARM, 32'h0);
    write_seq(32'h50, 2, 32'h50, acc);
    chk("post_busy", busy, 1);
    mwr_tvalid = 1'b1; mwr_tdata = 32'h52;
    #2 rst = 1'b1;
    #1;
    chk("arst_tready", mwr_tready, 0); chk("arst_busy", busy, 0);
    chk("arst_rvalid", mrd_tvalid, 0); chk("arst_rlast", mrd_tlast, 0);
    chk("arst_rdata", mrd_tdata, 0);   chk("arst_rkeep", mrd_tkeep, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0); chk("post_rst_tready", mwr_tready, 0);
    mwr_tvalid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_buffer.md
CAPTURE_BUFFER -- requirements
Module: capture_buffer

Interface
REQ-001 Parameter MDW, default 32, sample width in bits; SHALL be a multiple of 8.
REQ-002 Parameter GN, default MDW/8, number of byte-wide channel groups.
REQ-003 Parameter DEPTH, default 1024, sample capacity; SHALL be a power of two >= 4.
REQ-004 Derived constant AW = clog2(DEPTH).
REQ-005 clk  input  1  single clock; all logic is on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cmd_valid  input  1  one-cycle command strobe.
REQ-008 cmd_code  input  2  command: 0 ABORT, 1 ARM, 2 READ, 3 CFG.
REQ-009 cmd_data  input  32  CFG payload: [GN-1:0] group enable mask; [16+AW-1:16] post-trigger count.
REQ-010 mwr_tvalid, mwr_tready, mwr_tlast, mwr_tdata  in/out/in/in  1/1/1/MDW  sample write stream; tlast marks the trigger sample.
REQ-011 mrd_tvalid, mrd_tready, mrd_tlast, mrd_tdata, mrd_tkeep  out/in/out/out/out  1/1/1/MDW/GN  readout stream.
REQ-012 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-013 The FSM SHALL have states IDLE, ARMED, POST, DONE, READ.
REQ-014 CFG SHALL load the mask and post count in IDLE or DONE only; in any other state, CFG SHALL be ignored.
REQ-015 ARM in any state SHALL clear the write pointer and fill count and enter ARMED on the next cycle; any read in progress SHALL be abandoned.
REQ-016 ABORT in any state SHALL enter IDLE on the next cycle and drop mrd_tvalid.
REQ-017 mwr_tready SHALL be 1 in ARMED and POST and 0 in every other state.
REQ-018 A write SHALL occur on mwr_tvalid & mwr_tready. Each write stores mwr_tdata at wptr, then wptr increments modulo DEPTH (ring wrap). The fill count increments, saturating at DEPTH.
REQ-019 ARMED, accepted write with tlast: if the post count is 0, enter DONE; otherwise load the post counter with the post count and enter POST.
REQ-020 POST: each accepted write decrements the post counter; the write that takes it to 0 SHALL cause entry to DONE on the next cycle. tlast in POST SHALL be ignored.
REQ-021 A post count >= DEPTH SHALL be clamped to DEPTH-1.
REQ-022 READ is accepted only in DONE; elsewhere it SHALL be ignored. On acceptance the read pointer SHALL be set to the oldest sample: wptr - fill (mod DEPTH). The remaining count SHALL be set to fill.
REQ-023 READ with fill = 0 SHALL return to DONE without asserting mrd_tvalid.
REQ-024 Readout SHALL follow stream rules: once asserted, mrd_tvalid, tdata, tkeep and tlast are held until mrd_tready.
REQ-025 Readout SHALL sustain one sample per cycle while mrd_tready = 1, despite the one-cycle RAM read latency. This requires a prefetch/skid stage of at least 2 entries.
REQ-026 The first mrd_tvalid SHALL appear no later than 2 cycles after READ is accepted.
REQ-027 mrd_tkeep SHALL equal the group mask. Bytes of disabled groups SHALL read as 0 on mrd_tdata.
REQ-028 mrd_tlast SHALL be asserted with the final sample. After that handshake the FSM returns to DONE, so data may be re-read.
REQ-029 cmd_valid and a stream handshake in the same cycle: the command takes effect and the handshake completes. ARM with a simultaneous write discards that write.

Reset
REQ-030 On rst the FSM SHALL enter IDLE, with wptr, rptr, fill, post counter = 0, mask = all ones, post count = 0.
REQ-031 During reset mwr_tready, mrd_tvalid, mrd_tlast and busy SHALL be 0, and mrd_tdata and mrd_tkeep SHALL be 0.
REQ-032 RAM contents SHALL NOT be reset.

Structure
REQ-033 The cmd_code enumeration and the FSM state enumeration SHALL reside in the shared package with the other command encodings.
REQ-034 Storage SHALL be a sub-module sdp_ram: simple dual-port, MDW x DEPTH, registered read, one clock.
REQ-035 The FSM, pointers and skid stage SHALL reside in capture_buffer.

Verification (MDW=32, DEPTH=16)
REQ-036 CFG mask=0xF post=3; ARM; write 0x00..0x09 with tlast on 0x05; READ, tready=1 -> output 0x00..0x08, tlast on 0x08, tkeep=0xF.
REQ-037 Wrap: post=4; write 0..29 with tlast on 25 -> capture stops after 29; READ -> 16 samples 14..29 in order, tlast on 29.
REQ-038 Backpressure: the scenario of REQ-036 with tready toggling 1,0,0,1 -> identical sequence, no drop or duplicate, outputs stable while stalled.
REQ-039 Mask=0x5, sample 0xAABBCCDD -> mrd_tdata=0x00BB00DD, mrd_tkeep=0x5.
REQ-040 ARM during READ after 3 samples -> mrd_tvalid low next cycle; state ARMED; fill=0; subsequent capture correct.
REQ-041 rst asserted in POST mid-write -> all outputs 0 immediately (asynchronous); after release state IDLE, mwr_tready=0.
